// File: rtl/coremesh_sram_arbiter.sv
// -----------------------------------------------------------------------------
// coremesh_sram_arbiter
//   Shares one byte-enable SRAM port between N_REQ cluster masters.
//   The grant is combinational and round-robin.  The SRAM command is registered
//   one cycle after the accept.  The completion is routed back to the winner
//   two cycles after the accept.  This completion covers both reads and writes.
//
// Optional build macro: COREMESH_SRAM_ARB_PRIO_EN
//   When defined, the module adds the req_prio input.  Valid requesters with
//   prio set form a high class.  The high class always wins over the rest.
//   Round-robin from the shared pointer applies within the winning class.
//
// Ports
//   clock            in   single clock, all logic on posedge
//   reset            in   synchronous, active-low
//   req_valid        in   [N_REQ]             request present
//   req_ready        out  [N_REQ]             one-hot grant (combinational)
//   req_adr          in   [N_REQ*ADR_WIDTH]   packed word addresses
//   req_we           in   [N_REQ]             1 = write, 0 = read
//   req_sel          in   [N_REQ*DAT_WIDTH/8] packed byte enables
//   req_dat_w        in   [N_REQ*DAT_WIDTH]   packed write data
//   req_prio         in   [N_REQ]             high-priority flag (macro only)
//   rsp_valid        out  [N_REQ]             one-hot completion strobe
//   rsp_dat_r        out  [DAT_WIDTH]         read data, 0 unless a read completes
//   sram_addr        out  [ADR_WIDTH]         SRAM address
//   sram_write_en    out                      SRAM write strobe
//   sram_byte_en     out  [DAT_WIDTH/8]       SRAM byte enables
//   sram_write_data  out  [DAT_WIDTH]         SRAM write data
//   sram_read_data   in   [DAT_WIDTH]         valid one cycle after address
// -----------------------------------------------------------------------------
module coremesh_sram_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADR_WIDTH = 20,
    parameter int DAT_WIDTH = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ*ADR_WIDTH-1:0]     req_adr,
    input  logic [N_REQ-1:0]               req_we,
    input  logic [N_REQ*DAT_WIDTH/8-1:0]   req_sel,
    input  logic [N_REQ*DAT_WIDTH-1:0]     req_dat_w,
`ifdef COREMESH_SRAM_ARB_PRIO_EN
    input  logic [N_REQ-1:0]               req_prio,
`endif
    output logic [N_REQ-1:0]               rsp_valid,
    output logic [DAT_WIDTH-1:0]           rsp_dat_r,
    output logic [ADR_WIDTH-1:0]           sram_addr,
    output logic                           sram_write_en,
    output logic [DAT_WIDTH/8-1:0]         sram_byte_en,
    output logic [DAT_WIDTH-1:0]           sram_write_data,
    input  logic [DAT_WIDTH-1:0]           sram_read_data
);

    localparam int SEL_W = DAT_WIDTH / 8;
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] rr_ptr_r;
    logic [N_REQ-1:0] elig_s;
    logic             grant_any_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic             accept_s;
    logic [N_REQ-1:0] req_ready_s;

    logic             s1_valid_r;     // command stage holds a live op
    logic [IDX_W-1:0] s1_idx_r;
    logic             s1_read_r;
    logic [N_REQ-1:0] s1_onehot_s;
    logic [N_REQ-1:0] rsp_valid_r;
    logic             rsp_read_r;     // the completing op is a read

    // Eligible set: the high-priority class when present, otherwise all valid.
    always_comb begin
`ifdef COREMESH_SRAM_ARB_PRIO_EN
        if ((req_valid & req_prio) != {N_REQ{1'b0}}) begin
            elig_s = req_valid & req_prio;
        end else begin
            elig_s = req_valid;
        end
`else
        elig_s = req_valid;
`endif
    end

    // Round-robin search starting at rr_ptr_r, ascending with wrap.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = {IDX_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_any_s && elig_s[(int'(rr_ptr_r) + k) % N_REQ]) begin
                grant_any_s = 1'b1;
                grant_idx_s = IDX_W'((int'(rr_ptr_r) + k) % N_REQ);
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // No accept can happen in a cycle whose closing edge applies reset.
    assign accept_s = grant_any_s & reset;

    // One-hot ready for the winner only.
    always_comb begin
        req_ready_s = {N_REQ{1'b0}};
        if (accept_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = {N_REQ{1'b0}};
        end
    end

    assign req_ready   = req_ready_s;
    assign s1_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << s1_idx_r;

    // Command stage, response stage and round-robin pointer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_r        <= {IDX_W{1'b0}};
            sram_addr       <= {ADR_WIDTH{1'b0}};
            sram_write_en   <= 1'b0;
            sram_byte_en    <= {SEL_W{1'b0}};
            sram_write_data <= {DAT_WIDTH{1'b0}};
            s1_valid_r      <= 1'b0;
            s1_idx_r        <= {IDX_W{1'b0}};
            s1_read_r       <= 1'b0;
            rsp_valid_r     <= {N_REQ{1'b0}};
            rsp_read_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                sram_addr       <= req_adr[grant_idx_s*ADR_WIDTH +: ADR_WIDTH];
                sram_write_en   <= req_we[grant_idx_s];
                sram_byte_en    <= req_sel[grant_idx_s*SEL_W +: SEL_W];
                sram_write_data <= req_dat_w[grant_idx_s*DAT_WIDTH +: DAT_WIDTH];
                s1_valid_r      <= 1'b1;
                s1_idx_r        <= grant_idx_s;
                s1_read_r       <= ~req_we[grant_idx_s];
                if (int'(grant_idx_s) == N_REQ - 1) begin
                    rr_ptr_r <= {IDX_W{1'b0}};
                end else begin
                    rr_ptr_r <= grant_idx_s + IDX_W'(1);
                end
            end else begin
                // Idle cycle: address and data hold, strobes drop.
                sram_write_en <= 1'b0;
                sram_byte_en  <= {SEL_W{1'b0}};
                s1_valid_r    <= 1'b0;
                s1_read_r     <= 1'b0;
            end
            rsp_valid_r <= s1_valid_r ? s1_onehot_s : {N_REQ{1'b0}};
            rsp_read_r  <= s1_valid_r & s1_read_r;
        end
    end

    assign rsp_valid = rsp_valid_r;
    // SRAM read data for the completing read passes through combinationally.
    assign rsp_dat_r = rsp_read_r ? sram_read_data : {DAT_WIDTH{1'b0}};

endmodule

// File: tb/tb_coremesh_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_coremesh_sram_arbiter
//   Directed bench for coremesh_sram_arbiter (N_REQ=4, ADR 20, DAT 32).
//   It contains a byte-enable SRAM model with one-cycle read latency.
// -----------------------------------------------------------------------------
module tb_coremesh_sram_arbiter;

    logic         clock;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [79:0]  req_adr;
    logic [3:0]   req_we;
    logic [15:0]  req_sel;
    logic [127:0] req_dat_w;
`ifdef COREMESH_SRAM_ARB_PRIO_EN
    logic [3:0]   req_prio;
`endif
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_dat_r;
    logic [19:0]  sram_addr;
    logic         sram_write_en;
    logic [3:0]   sram_byte_en;
    logic [31:0]  sram_write_data;
    logic [31:0]  sram_read_data;

    logic [31:0]  mem [256];
    int           checks;
    int           errors;

    coremesh_sram_arbiter dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_adr         (req_adr),
        .req_we          (req_we),
        .req_sel         (req_sel),
        .req_dat_w       (req_dat_w),
`ifdef COREMESH_SRAM_ARB_PRIO_EN
        .req_prio        (req_prio),
`endif
        .rsp_valid       (rsp_valid),
        .rsp_dat_r       (rsp_dat_r),
        .sram_addr       (sram_addr),
        .sram_write_en   (sram_write_en),
        .sram_byte_en    (sram_byte_en),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM model: byte-enable write, read data registered one cycle later.
    always @(posedge clock) begin
        if (sram_write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_byte_en[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_write_data[8*b +: 8];
            end
        end
        sram_read_data <= mem[sram_addr[7:0]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [19:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_adr[i*20 +: 20]   = adr;
        req_sel[i*4 +: 4]     = sel;
        req_dat_w[i*32 +: 32] = dat;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        req_valid = 4'h0;
        req_we    = 4'h0;
        req_adr   = 80'h0;
        req_sel   = 16'h0;
        req_dat_w = 128'h0;
`ifdef COREMESH_SRAM_ARB_PRIO_EN
        req_prio  = 4'h0;
`endif
        for (int a = 0; a < 256; a++) mem[a] = 32'h0;

        // 1: reset held 5 cycles with a request pending
        set_req(0, 1'b1, 1'b1, 20'h00055, 4'hF, 32'h12345678);
        repeat (5) step();
        check("rst_ready", req_ready, 4'h0);
        check("rst_rsp_valid", rsp_valid, 4'h0);
        check("rst_rsp_dat", rsp_dat_r, 32'h0);
        check("rst_addr", sram_addr, 20'h0);
        check("rst_we", sram_write_en, 1'b0);
        check("rst_be", sram_byte_en, 4'h0);
        check("rst_wd", sram_write_data, 32'h0);
        set_req(0, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
        reset = 1'b1;
        #1;
        check("idle_ready", req_ready, 4'h0);
        step();
        check("idle_we", sram_write_en, 1'b0);
        check("idle_rsp", rsp_valid, 4'h0);

        // 2: req 1 writes then reads 0x00010
        set_req(1, 1'b1, 1'b1, 20'h00010, 4'hF, 32'hDEADBEEF);
        #1;
        check("t2_wr_grant", req_ready, 4'b0010);
        step();
        set_req(1, 1'b1, 1'b0, 20'h00010, 4'hF, 32'h0);
        #1;
        check("t2_sram_addr", sram_addr, 20'h00010);
        check("t2_sram_we", sram_write_en, 1'b1);
        check("t2_sram_be", sram_byte_en, 4'hF);
        check("t2_sram_wd", sram_write_data, 32'hDEADBEEF);
        check("t2_rd_grant", req_ready, 4'b0010);
        step();
        set_req(1, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
        #1;
        check("t2_wr_rsp", rsp_valid, 4'b0010);
        check("t2_wr_rsp_dat", rsp_dat_r, 32'h0);
        check("t2_rd_we", sram_write_en, 1'b0);
        check("t2_rd_be", sram_byte_en, 4'hF);
        step();
        check("t2_rd_rsp", rsp_valid, 4'b0010);
        check("t2_rd_dat", rsp_dat_r, 32'hDEADBEEF);
        check("t2_idle_be", sram_byte_en, 4'h0);
        check("t2_hold_addr", sram_addr, 20'h00010);
        step();
        check("t2_rsp_once", rsp_valid, 4'h0);

        // 4: pointer at 2 -> req 2, then 3 ahead of 0
        set_req(2, 1'b1, 1'b0, 20'h00020, 4'hF, 32'h0);
        #1;
        check("t4_grant2", req_ready, 4'b0100);
        step();
        set_req(2, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
        set_req(0, 1'b1, 1'b0, 20'h00030, 4'hF, 32'h0);
        set_req(3, 1'b1, 1'b0, 20'h00040, 4'hF, 32'h0);
        #1;
        check("t4_grant3", req_ready, 4'b1000);
        step();
        set_req(3, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
        #1;
        check("t4_grant0", req_ready, 4'b0001);
        check("t4_rsp2", rsp_valid, 4'b0100);
        step();
        set_req(0, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
        #1;
        check("t4_rsp3", rsp_valid, 4'b1000);
        step();
        check("t4_rsp0", rsp_valid, 4'b0001);

        // 5: partial-byte write then read back
        set_req(0, 1'b1, 1'b1, 20'h00010, 4'b0010, 32'h0000AB00);
        #1;
        check("t5_wr_grant", req_ready, 4'b0001);
        step();
        set_req(0, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
        set_req(2, 1'b1, 1'b0, 20'h00010, 4'hF, 32'h0);
        #1;
        check("t5_rd_grant", req_ready, 4'b0100);
        check("t5_be", sram_byte_en, 4'b0010);
        check("t5_wd", sram_write_data, 32'h0000AB00);
        step();
        set_req(2, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
        #1;
        check("t5_wr_rsp", rsp_valid, 4'b0001);
        step();
        check("t5_rd_rsp", rsp_valid, 4'b0100);
        check("t5_rd_dat", rsp_dat_r, 32'hDEADABEF);
        step();

        // 3: all four valid from reset release
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 20'h00010, 4'hF, 32'h0);
        step();
        step();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("t3_grant", req_ready, 64'(4'b0001 << (k % 4)));
            if (k >= 2) begin
                check("t3_rsp", rsp_valid, 64'(4'b0001 << ((k - 2) % 4)));
                check("t3_dat", rsp_dat_r, 32'hDEADABEF);
            end
            step();
        end
        req_valid = 4'h0;
        #1;
        check("t3_rsp_tail0", rsp_valid, 4'b0100);
        step();
        check("t3_rsp_tail1", rsp_valid, 4'b1000);
        step();
        check("t3_drained", rsp_valid, 4'h0);

        // Single requester: granted every cycle
        set_req(2, 1'b1, 1'b0, 20'h00010, 4'hF, 32'h0);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("single_grant", req_ready, 4'b0100);
            step();
        end
        set_req(2, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
        step();
        step();
        step();

        // 6: reset one cycle after a read accept kills its response
        set_req(1, 1'b1, 1'b0, 20'h00010, 4'hF, 32'h0);
        #1;
        check("t6_grant", req_ready, 4'b0010);
        step();
        set_req(1, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("t6_no_rsp", rsp_valid, 4'h0);
        check("t6_rst_be", sram_byte_en, 4'h0);
        step();
        check("t6_no_rsp_late", rsp_valid, 4'h0);

`ifdef COREMESH_SRAM_ARB_PRIO_EN
        // Priority: req 2 flagged wins over req 0 despite pointer at 0
        set_req(0, 1'b1, 1'b0, 20'h00010, 4'hF, 32'h0);
        set_req(2, 1'b1, 1'b0, 20'h00010, 4'hF, 32'h0);
        req_prio = 4'b0100;
        #1;
        check("prio_grant2", req_ready, 4'b0100);
        step();
        set_req(2, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
        req_prio = 4'h0;
        #1;
        check("prio_then0", req_ready, 4'b0001);
        step();
        set_req(0, 1'b0, 1'b0, 20'h0, 4'h0, 32'h0);
        step();
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
